// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: per-channel debounce state encoding and default timing parameters
package key_debounce_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int LONG_CYCLES_DEF = 100_000_000;
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one button's synchronizer, debounce FSM and event pulses
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_channel
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
   logic s1_q, s_q;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic level_q, level_d, press_q, press_d, release_q, release_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s_q <= 1'b0;
         state_q <= IDLE;
         cnt_q <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q <= key_raw_i;
         s_q <= s1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         release_q <= release_d;
      end
   end
   // A completing edge still needs s at that edge; otherwise the bounce path wins.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE:
            if (s_q) begin
               state_d = PRESS_WAIT;
               cnt_d = CW'(1);
            end
         PRESS_WAIT:
            if (!s_q) begin
               state_d = IDLE;
               cnt_d = '0;
            end else if (cnt_q == CMAX) begin
               state_d = HELD;
               cnt_d = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         HELD:
            if (!s_q) begin
               state_d = RELEASE_WAIT;
               cnt_d = CW'(1);
            end
         RELEASE_WAIT:
            if (s_q) begin
               state_d = HELD;
               cnt_d = '0;
            end else if (cnt_q == CMAX) begin
               state_d = IDLE;
               cnt_d = '0;
               level_d = 1'b0;
               release_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   assign level_o = level_q;
   assign press_o = press_q;
   assign release_o = release_q;
`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES);
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic long_q, long_d, lrun;
   // The release edge itself does not count, so key_long never coincides with key_release.
   always_comb begin
      lrun = (state_q == HELD || state_q == RELEASE_WAIT) && state_d != IDLE && lcnt_q != LMAX;
      lcnt_d = (state_q == PRESS_WAIT && state_d == HELD) ? '0 : lrun ? lcnt_q + 1'b1 : lcnt_q;
      long_d = lrun && lcnt_q == LMAX - 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         long_q <= long_d;
      end
   end
   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: N_KEYS independent button conditioners giving level and press/release/long pulses
// Optional long-press events are enabled by defining KEY_LONG_PRESS_EN.
module key_debounce_fsm
   import key_debounce_pkg::*;
#(
   parameter int N_KEYS = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);
   if (N_KEYS < 1 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
      $error("key_debounce_fsm: parameter out of range");
   end
   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES(LONG_CYCLES)
      ) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .key_raw_i(key_raw[i]),
         .level_o(key_level[i]),
         .press_o(key_press[i]),
         .release_o(key_release[i]),
         .long_o(key_long[i])
      );
   end
endmodule

// File: tb/tb_key_debounce_fsm.sv
// tb_key_debounce_fsm: directed and random stimulus against a run-length reference model
module tb_key_debounce_fsm;
   localparam int N = 2;
   localparam int D = 4;
   localparam int L = 20;
`ifdef KEY_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0] key_raw, key_level, key_press, key_release, key_long;
   key_debounce_fsm #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_level(key_level),
      .key_press(key_press), .key_release(key_release), .key_long(key_long)
   );
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0, ec = 0;
   int run [N];
   int lt [N];
   logic [N-1:0] sy1, sy2, e_lvl, e_pr, e_rl, e_lg;
   int np0, nr0, nl0, pe, re, any_out;
   logic [N-1:0] pv;
   // A change is accepted once D+1 consecutive synchronized samples disagree with the level.
   function automatic void model_edge(input logic [N-1:0] raw);
      for (int c = 0; c < N; c++) begin
         logic s;
         s = sy2[c];
         e_pr[c] = 1'b0;
         e_rl[c] = 1'b0;
         e_lg[c] = 1'b0;
         run[c] = (s != e_lvl[c]) ? run[c] + 1 : 0;
         if (run[c] == D + 1) begin
            e_lvl[c] = s;
            run[c] = 0;
            if (s) begin
               e_pr[c] = 1'b1;
               lt[c] = 0;
            end else e_rl[c] = 1'b1;
         end else if (e_lvl[c] && lt[c] < L) begin
            lt[c]++;
            e_lg[c] = LONG_EN && lt[c] == L;
         end
      end
      sy2 = sy1;
      sy1 = raw;
   endfunction
   function automatic void model_reset();
      sy1 = '0; sy2 = '0; e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0;
      for (int c = 0; c < N; c++) begin
         run[c] = 0;
         lt[c] = 0;
      end
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_outs();
      chk("level", 32'(key_level), 32'(e_lvl));
      chk("press", 32'(key_press), 32'(e_pr));
      chk("release", 32'(key_release), 32'(e_rl));
      chk("long", 32'(key_long), 32'(e_lg));
   endtask
   task automatic clr();
      np0 = 0; nr0 = 0; nl0 = 0; pe = -1; re = -1; any_out = 0; pv = '0;
   endtask
   task automatic step(input logic [N-1:0] raw);
      key_raw = raw;
      @(posedge clk);
      ec++;
      model_edge(raw);
      #1;
      chk_outs();
      np0 += int'(key_press[0]);
      nr0 += int'(key_release[0]);
      nl0 += int'(key_long[0]);
      any_out += int'(|{key_level, key_press, key_release, key_long});
      if (key_press[0] && pe < 0) pe = ec;
      if (key_release[0] && re < 0) re = ec;
      if (key_press != '0 && pv == '0) pv = key_press;
   endtask
   task automatic steps(input logic [N-1:0] raw, input int n);
      for (int i = 0; i < n; i++) step(raw);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int k;
      rst_n = 1'b0;
      key_raw = '0;
      model_reset();
      clr();
      #2;
      chk_outs();
      @(negedge clk);
      rst_n = 1'b1;
      // clean press then clean release on channel 0
      steps(2'b00, 5);
      clr();
      k = ec + 1;
      steps(2'b01, 10);
      chk("press_latency", pe - k, D + 2);
      chk("press_count", np0, 1);
      chk("press_level", key_level, 2'b01);
      k = ec + 1;
      steps(2'b00, 10);
      chk("release_latency", re - k, D + 2);
      chk("release_count", nr0, 1);
      // short bounce must be rejected entirely
      clr();
      steps(2'b01, 3); steps(2'b00, 1); steps(2'b01, 2); steps(2'b00, 8);
      chk("bounce_quiet", any_out, 0);
      // bounce, settle high, then release
      clr();
      steps(2'b01, 2); steps(2'b00, 1); steps(2'b01, 3); steps(2'b00, 1); steps(2'b01, 12);
      k = ec + 1;
      steps(2'b00, 10);
      chk("settle_press", np0, 1);
      chk("settle_release", nr0, 1);
      chk("settle_rel_latency", re - k, D + 2);
      chk("settle_level", key_level, 2'b00);
      // simultaneous channels
      clr();
      steps(2'b11, 10);
      chk("simul_press", pv, 2'b11);
      steps(2'b00, 10);
      // long press
      clr();
      steps(2'b01, D + 3 + 40);
      chk("long_count", nl0, LONG_EN ? 1 : 0);
      chk("long_press_count", np0, 1);
      steps(2'b00, 10);
      // reset mid-count with the button held through release
      steps(2'b01, 5);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_outs();
      @(posedge clk);
      #1;
      chk_outs();
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      k = ec + 1;
      steps(2'b01, 10);
      chk("reset_press_latency", pe - k, D + 2);
      chk("reset_press_count", np0, 1);
      steps(2'b00, 10);
      // randomized segments
      for (int i = 0; i < 60; i++) steps(N'($urandom_range(0, 3)), $urandom_range(1, 9));
      steps(2'b11, 30);
      steps(2'b00, 12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
